// File: rtl/trigger_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_sequencer: programmable burst generator for per-chip triggers.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module trigger_sequencer #(
  parameter int NUM_CHIPS  = 4,
  parameter int CNT_BITS   = 24,
  parameter int PW_BITS    = 8,
  parameter int NTRIG_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_CHIPS-1:0]  trig_mask,
  input  logic [CNT_BITS-1:0]   holdoff,
  input  logic [CNT_BITS-1:0]   period,
  input  logic [PW_BITS-1:0]    pulse_width,
  input  logic [NTRIG_BITS-1:0] num_trig,
  input  logic                  rr_mode,
  output logic [NUM_CHIPS-1:0]  external_trigger,
  output logic                  busy,
  output logic                  done,
  output logic [NTRIG_BITS-1:0] trig_count
);

  localparam int PTR_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
  localparam logic [NUM_CHIPS-1:0] ONE_HOT0 = NUM_CHIPS'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    PULSE   = 2'd2,
    GAP     = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [CNT_BITS-1:0]   cnt, cnt_n;
  logic [PTR_W-1:0]      ptr, ptr_n;
  logic [NUM_CHIPS-1:0]  mask_l;
  logic                  rr_l;
  logic [NTRIG_BITS-1:0] ntrig_l;
  logic [PW_BITS-1:0]    wm1_l;
  logic [CNT_BITS-1:0]   gap_l;

  logic [NUM_CHIPS-1:0]  trig_n;
  logic                  busy_n, done_n, load_cfg, fire, fire_rr;
  logic [NTRIG_BITS-1:0] count_n;
  logic [PTR_W-1:0]      fire_ptr, start_ptr;
  logic [NUM_CHIPS-1:0]  fire_mask;
  logic [PW_BITS-1:0]    fire_wm1, pw_eff;
  logic [CNT_BITS-1:0]   w_ext, p_eff, gap_len;

  // Circular search for the next set mask bit strictly after p (p itself last).
  function automatic logic [PTR_W-1:0] next_set(input logic [NUM_CHIPS-1:0] m,
                                                input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    logic [PTR_W-1:0] cand;
    logic             found;
    r     = p;
    found = 1'b0;
    for (int i = 1; i <= NUM_CHIPS; i++) begin
      cand = PTR_W'((int'(p) + i) % NUM_CHIPS);
      if (!found && m[cand]) begin
        r     = cand;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    pw_eff    = (pulse_width == '0) ? PW_BITS'(1) : pulse_width;
    w_ext     = CNT_BITS'(pw_eff);
    p_eff     = (period > w_ext) ? period : (w_ext + CNT_BITS'(1));
    gap_len   = p_eff - w_ext - CNT_BITS'(1);
    start_ptr = trig_mask[ptr] ? ptr : next_set(trig_mask, ptr);
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    trig_n    = '0;
    busy_n    = busy;
    done_n    = 1'b0;
    count_n   = trig_count;
    load_cfg  = 1'b0;
    fire      = 1'b0;
    fire_ptr  = ptr;
    fire_mask = mask_l;
    fire_rr   = rr_l;
    fire_wm1  = wm1_l;

    case (state)
      IDLE: begin
        if (start && !abort && (|trig_mask)) begin
          load_cfg = 1'b1;
          busy_n   = 1'b1;
          count_n  = '0;
          ptr_n    = start_ptr;
          if (holdoff != '0) begin
            state_n = HOLDOFF;
            cnt_n   = holdoff - CNT_BITS'(1);
          end else begin
            fire      = 1'b1;
            fire_ptr  = start_ptr;
            fire_mask = trig_mask;
            fire_rr   = rr_mode;
            fire_wm1  = pw_eff - PW_BITS'(1);
          end
        end
      end
      HOLDOFF, GAP: begin
        if (cnt == '0) fire = 1'b1;
        else           cnt_n = cnt - CNT_BITS'(1);
      end
      PULSE: begin
        trig_n = external_trigger;
        if (cnt == '0) begin
          trig_n = '0;
          if (rr_l) ptr_n = next_set(mask_l, ptr);
          if ((ntrig_l != '0) && (trig_count == ntrig_l)) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = GAP;
            cnt_n   = gap_l;
          end
        end else begin
          cnt_n = cnt - CNT_BITS'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Rising-edge cycle: outputs and the pulse count update together.
    if (fire) begin
      state_n = PULSE;
      cnt_n   = CNT_BITS'(fire_wm1);
      count_n = count_n + NTRIG_BITS'(1);
      trig_n  = fire_rr ? (ONE_HOT0 << fire_ptr) : fire_mask;
    end

    if (abort && (state != IDLE)) begin
      state_n = IDLE;
      trig_n  = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
      count_n = trig_count;
      ptr_n   = ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      ptr              <= '0;
      mask_l           <= '0;
      rr_l             <= 1'b0;
      ntrig_l          <= '0;
      wm1_l            <= '0;
      gap_l            <= '0;
      external_trigger <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      trig_count       <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      ptr              <= ptr_n;
      external_trigger <= trig_n;
      busy             <= busy_n;
      done             <= done_n;
      trig_count       <= count_n;
      if (load_cfg) begin
        mask_l  <= trig_mask;
        rr_l    <= rr_mode;
        ntrig_l <= num_trig;
        wm1_l   <= pw_eff - PW_BITS'(1);
        gap_l   <= gap_len;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trigger_sequencer: vector table, corner sequences, randomized bursts. |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_trigger_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, rr_mode;
  logic [3:0]  trig_mask;
  logic [23:0] holdoff, period;
  logic [7:0]  pulse_width;
  logic [15:0] num_trig;
  logic [3:0]  external_trigger;
  logic        busy, done;
  logic [15:0] trig_count;

  trigger_sequencer #(
    .NUM_CHIPS(4), .CNT_BITS(24), .PW_BITS(8), .NTRIG_BITS(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .trig_mask(trig_mask), .holdoff(holdoff), .period(period),
    .pulse_width(pulse_width), .num_trig(num_trig), .rr_mode(rr_mode),
    .external_trigger(external_trigger), .busy(busy), .done(done),
    .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mptr     = 0;
  int mcount   = 0;
  logic [3:0] obs_ext [256];
  int obs_done_rel;
  int obs_count;

  typedef struct {
    int hold; int per; int pw; int n; logic [3:0] mask; bit rr; int abort_at;
    int exp_done; int exp_count; int rise1; int out1; int rise2; int out2;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int count_at(input int r, input int first, input int p, input int n);
    int c;
    if (r < first) return 0;
    c = (r - first) / p + 1;
    if (n > 0 && c > n) c = n;
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mptr = 0;
    mcount = 0;
  endtask

  task automatic idle_check(input string name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({name, "_ext"}, int'(external_trigger), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_count"}, int'(trig_count), mcount);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
    end
  endtask

  // Accept a burst at rel 0 and check every following cycle against the
  // analytic waveform: pulse k rises at 1+holdoff+k*P and is high for W cycles.
  task automatic run_burst(input int hold, input int per, input int pw, input int n,
                           input logic [3:0] mask, input bit rr, input int abort_at,
                           input bit wiggle);
    int W, P, first, E, rel_end, i0, len, k, exp_ext, exp_busy, exp_done, exp_cnt;
    bit aborted;
    int chips[$];
    W = (pw == 0) ? 1 : pw;
    P = (per > W) ? per : W + 1;
    first = 1 + hold;
    E = (n == 0) ? 32'h4000_0000 : first + (n - 1) * P + W;
    aborted = (abort_at > 0) && (abort_at < E);
    rel_end = aborted ? abort_at + 3 : E + 2;
    for (int c = 0; c < 4; c++) if (mask[c]) chips.push_back(c);
    len = chips.size();
    i0 = 0;
    for (int j = len - 1; j >= 0; j--) if (chips[j] >= mptr) i0 = j;
    start = 1'b1; abort = 1'b0; trig_mask = mask;
    holdoff = 24'(hold); period = 24'(per); pulse_width = 8'(pw);
    num_trig = 16'(n); rr_mode = rr;
    obs_done_rel = 0;
    @(posedge clk); #1;
    for (int rel = 1; rel <= rel_end; rel++) begin
      abort = (rel == abort_at);
      start = 1'b0;
      if (wiggle && rel < E && (abort_at == 0 || rel <= abort_at)) begin
        start       = ($urandom_range(0, 2) == 0);
        trig_mask   = 4'($urandom);
        holdoff     = 24'($urandom_range(0, 3));
        period      = 24'($urandom_range(0, 9));
        pulse_width = 8'($urandom_range(0, 4));
        num_trig    = 16'($urandom_range(0, 3));
        rr_mode     = 1'($urandom);
      end
      @(negedge clk);
      if (aborted && rel > abort_at) begin
        exp_ext = 0; exp_busy = 0; exp_done = 0;
        exp_cnt = count_at(abort_at, first, P, n);
      end else if (rel >= E) begin
        exp_ext = 0; exp_busy = 0; exp_done = (rel == E) ? 1 : 0; exp_cnt = n;
      end else begin
        exp_busy = 1; exp_done = 0; exp_ext = 0;
        exp_cnt = count_at(rel, first, P, n);
        if (rel >= first && (rel - first) % P < W) begin
          k = (rel - first) / P;
          exp_ext = rr ? (1 << chips[(i0 + k) % len]) : int'(mask);
        end
      end
      chk("external_trigger", int'(external_trigger), exp_ext);
      chk("busy", int'(busy), exp_busy);
      chk("done", int'(done), exp_done);
      chk("trig_count", int'(trig_count), exp_cnt);
      if (rel < 256) obs_ext[rel] = external_trigger;
      if (done && obs_done_rel == 0) obs_done_rel = rel;
      obs_count = int'(trig_count);
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0;
    mcount = aborted ? count_at(abort_at, first, P, n) : n;
    if (rr) mptr = chips[(i0 + mcount) % len];
    else    mptr = chips[i0];
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 10, 3, 2, 4'b1111, 1'b0, 0, 14, 2, 1, 15, 11, 15};
    tbl[1] = '{5, 1, 1, 3, 4'b0001, 1'b0, 0, 11, 3, 6, 1, 8, 1};
    tbl[2] = '{0, 4, 2, 4, 4'b1010, 1'b1, 0, 15, 4, 1, 2, 5, 8};
    tbl[3] = '{0, 5, 2, 0, 4'b1111, 1'b0, 11, 0, 3, 1, 15, 6, 15};
    tbl[4] = '{2, 0, 0, 2, 4'b0011, 1'b0, 0, 6, 2, 3, 3, 5, 3};
    tbl[5] = '{1, 3, 1, 3, 4'b0100, 1'b1, 0, 9, 3, 2, 4, 5, 4};

    start = 0; abort = 0; rr_mode = 0; trig_mask = 0; holdoff = 0;
    period = 0; pulse_width = 0; num_trig = 0; reset = 0;
    do_reset();
    @(negedge clk);
    chk("reset_ext", int'(external_trigger), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_count", int'(trig_count), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_burst(tbl[i].hold, tbl[i].per, tbl[i].pw, tbl[i].n, tbl[i].mask,
                tbl[i].rr, tbl[i].abort_at, 1'b1);
      chk("vec_done_cycle", obs_done_rel, tbl[i].exp_done);
      chk("vec_final_count", obs_count, tbl[i].exp_count);
      chk("vec_rise1", int'(obs_ext[tbl[i].rise1]), tbl[i].out1);
      chk("vec_rise2", int'(obs_ext[tbl[i].rise2]), tbl[i].out2);
    end

    // Ignored starts: zero mask, and start together with abort in IDLE.
    start = 1'b1; trig_mask = 4'b0000; holdoff = 0; pulse_width = 2; period = 4;
    num_trig = 2; rr_mode = 0;
    idle_check("mask0_start");
    start = 1'b1; abort = 1'b1; trig_mask = 4'b1111;
    idle_check("start_abort");
    abort = 1'b1;
    idle_check("idle_abort");

    // Reset in the middle of a pulse, then a fresh burst.
    do_reset();
    start = 1'b1; trig_mask = 4'b1111; holdoff = 0; pulse_width = 4;
    period = 10; num_trig = 3; rr_mode = 0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_ext", int'(external_trigger), 15);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_ext", int'(external_trigger), 0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_count", int'(trig_count), 0);
    chk("midreset_done", int'(done), 0);
    @(posedge clk); #1;
    mptr = 0; mcount = 0;
    run_burst(1, 4, 2, 2, 4'b0110, 1'b1, 0, 1'b0);

    // Randomized groups; round-robin groups chain bursts to exercise pointer persistence.
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int b = 0; b < 4; b++) begin
        int hold, per, pw, n, ab;
        logic [3:0] m;
        bit rrg;
        rrg  = (g % 2) == 1;
        m    = 4'($urandom_range(1, 15));
        hold = $urandom_range(0, 6);
        per  = $urandom_range(0, 11);
        pw   = $urandom_range(0, 4);
        n    = $urandom_range(1, 5);
        ab   = 0;
        if (!rrg && $urandom_range(0, 2) == 0) begin
          n  = $urandom_range(0, 4);
          ab = $urandom_range(1, 30);
        end
        run_burst(hold, per, pw, n, m, rrg, ab, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
